// File: rtl/ram_bank.sv
// ram_bank: parametrised single-port synchronous RAM with per-byte write
// enables, a registered read-valid strobe and a hardware clear sequencer.
// After reset, or on a clr request, the sequencer sweeps every word to
// zero. Accesses are ignored while it runs.
//
// Ports:
//   clk     memory clock, all logic on the rising edge
//   reset   synchronous active-high reset; starts a clear sweep
//   clr     single-cycle request to zero the whole memory (IDLE only)
//   cen     chip enable
//   wen     1 = write, 0 = read, qualified by cen
//   ben     byte-lane write enables; bit i covers din[8i+7:8i]
//   addr    word address
//   din     write data
//   dout    registered read data; zero whenever dvalid is low
//   dvalid  dout holds read data from the previous cycle's read
//   busy    clear sweep in progress
//
// FSM states:
//   state | meaning
//   IDLE  | normal read/write accesses
//   CLEAR | zeroing mem[ptr], one word per cycle, accesses ignored
module ram_bank #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clr,
  input  logic                  cen,
  input  logic                  wen,
  input  logic [DATA_W/8-1:0]   ben,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [DATA_W-1:0]     din,
  output logic [DATA_W-1:0]     dout,
  output logic                  dvalid,
  output logic                  busy
);

  localparam int NB    = DATA_W / 8;
  localparam int DEPTH = 1 << ADDR_W;
  localparam int PTR_W = ADDR_W + 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t              state;
  logic [PTR_W-1:0]    ptr;
  logic [DATA_W-1:0]   mem [DEPTH];

  logic clear_we;
  logic access_ok;
  logic write_en;

  // The sweep writes on every non-reset edge in CLEAR, including the one
  // that returns to IDLE. An IDLE edge with clr set performs no access.
  assign clear_we  = (state == CLEAR) && !reset;
  assign access_ok = (state == IDLE) && !reset && !clr && cen;
  assign write_en  = access_ok && wen;

  // Storage has no reset so it can map onto RAM macros; the sweep is the
  // only thing that defines its contents.
  always_ff @(posedge clk) begin
    if (clear_we) begin
      mem[ptr[ADDR_W-1:0]] <= '0;
    end else if (write_en) begin
      for (int i = 0; i < NB; i++) begin
        if (ben[i]) begin
          mem[addr][8*i +: 8] <= din[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= CLEAR;
      ptr    <= '0;
      dout   <= '0;
      dvalid <= 1'b0;
      busy   <= 1'b1;
    end else begin
      dout   <= '0;
      dvalid <= 1'b0;
      case (state)
        CLEAR: begin
          ptr <= ptr + PTR_W'(1);
          if (ptr == LAST_PTR) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        IDLE: begin
          if (clr) begin
            state <= CLEAR;
            ptr   <= '0;
            busy  <= 1'b1;
          end else if (cen && !wen) begin
            // Old contents: a single port cannot read and write together.
            dout   <= mem[addr];
            dvalid <= 1'b1;
          end
        end
        default: begin
          state <= CLEAR;
          ptr   <= '0;
          busy  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_bank.sv
module tb_ram_bank;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // default 32x32 instance
  logic        reset, clr, cen, wen;
  logic [3:0]  ben;
  logic [4:0]  addr;
  logic [31:0] din, dout;
  logic        dvalid, busy;

  // narrow 8x16 instance
  logic        reset2, clr2, cen2, wen2;
  logic [1:0]  ben2;
  logic [2:0]  addr2;
  logic [15:0] din2, dout2;
  logic        dvalid2, busy2;

  int passed = 0;
  int total  = 0;

  ram_bank dut (
    .clk(clk), .reset(reset), .clr(clr), .cen(cen), .wen(wen), .ben(ben),
    .addr(addr), .din(din), .dout(dout), .dvalid(dvalid), .busy(busy)
  );

  ram_bank #(.DATA_W(16), .ADDR_W(3)) dut2 (
    .clk(clk), .reset(reset2), .clr(clr2), .cen(cen2), .wen(wen2), .ben(ben2),
    .addr(addr2), .din(din2), .dout(dout2), .dvalid(dvalid2), .busy(busy2)
  );

  // advance one edge; inputs and outputs are handled 1 time unit after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    clr = 0; cen = 0; wen = 0; ben = 4'h0; addr = '0; din = '0;
  endtask

  // count edges until busy falls, bounded
  task automatic count_busy(output int n);
    n = 0;
    while (busy && n < 200) begin
      step();
      n++;
    end
  endtask

  task automatic do_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] b);
    cen = 1; wen = 1; addr = a; din = d; ben = b;
    step();
  endtask

  task automatic test_reset();
    int n;
    idle_inputs();
    reset = 1;
    step();
    step();
    total++;
    if (busy !== 1'b1 || dvalid !== 1'b0 || dout !== 32'h0)
      $display("FAIL reset_state: busy=%b dvalid=%b dout=%h, need busy=1 dvalid=0 dout=0",
               busy, dvalid, dout);
    else passed++;
    reset = 0;
    count_busy(n);
    total++;
    if (n !== 32) $display("FAIL reset_busy_len: got %0d cycles, need 32", n);
    else passed++;
  endtask

  task automatic test_read_all_zero();
    int bad = 0;
    for (int a = 0; a < 32; a++) begin
      cen = 1; wen = 0; addr = a[4:0];
      step();
      if (dout !== 32'h0 || dvalid !== 1'b1) begin
        bad++;
        $display("FAIL zero_read addr %0d: dout=%h dvalid=%b, need 0 and 1", a, dout, dvalid);
      end
    end
    total++;
    if (bad == 0) passed++;
    cen = 0;
    step();
    total++;
    if (dvalid !== 1'b0 || dout !== 32'h0)
      $display("FAIL cen_low: dvalid=%b dout=%h, need 0 and 0", dvalid, dout);
    else passed++;
  endtask

  task automatic test_write_read();
    do_write(5'd5, 32'hDEADBEEF, 4'hF);
    total++;
    if (dout !== 32'h0 || dvalid !== 1'b0)
      $display("FAIL write_cycle_out: dout=%h dvalid=%b, need 0 and 0", dout, dvalid);
    else passed++;
    wen = 0;
    step();
    total++;
    if (dout !== 32'hDEADBEEF || dvalid !== 1'b1)
      $display("FAIL full_write_read: dout=%h dvalid=%b, need deadbeef and 1", dout, dvalid);
    else passed++;
  endtask

  task automatic test_byte_lanes();
    do_write(5'd5, 32'h11223344, 4'b0101);
    wen = 0;
    step();
    total++;
    if (dout !== 32'hDE22BE44 || dvalid !== 1'b1)
      $display("FAIL byte_write: dout=%h dvalid=%b, need de22be44 and 1", dout, dvalid);
    else passed++;
    do_write(5'd5, 32'hFFFFFFFF, 4'b0000);
    wen = 0;
    step();
    total++;
    if (dout !== 32'hDE22BE44)
      $display("FAIL ben_zero: dout=%h, need de22be44", dout);
    else passed++;
    do_write(5'd9, 32'hCAFEF00D, 4'b1010);
    wen = 0;
    step();
    total++;
    if (dout !== 32'hCA00F000)
      $display("FAIL byte_write_b: dout=%h, need ca00f000", dout);
    else passed++;
  endtask

  task automatic test_back_to_back();
    do_write(5'd20, 32'h0BADCAFE, 4'hF);
    wen = 0;
    step();
    total++;
    if (dout !== 32'h0BADCAFE || dvalid !== 1'b1)
      $display("FAIL back_to_back: dout=%h dvalid=%b, need 0badcafe and 1", dout, dvalid);
    else passed++;
  endtask

  task automatic test_clear();
    int n;
    int bad = 0;
    for (int a = 0; a < 32; a++) do_write(a[4:0], 32'(a * 3), 4'hF);
    cen = 1; wen = 0; addr = 5'd31;
    step();
    total++;
    if (dout !== 32'd93) $display("FAIL fill_check: dout=%h, need 0000005d", dout);
    else passed++;
    addr = 5'd7;
    clr = 1;
    step();
    clr = 0;
    total++;
    if (busy !== 1'b1 || dvalid !== 1'b0)
      $display("FAIL clr_start: busy=%b dvalid=%b, need 1 and 0", busy, dvalid);
    else passed++;
    n = 0;
    while (busy && n < 200) begin
      step();
      n++;
      if (dvalid !== 1'b0) bad++;
    end
    total++;
    if (n !== 32) $display("FAIL clr_busy_len: got %0d cycles, need 32", n);
    else passed++;
    total++;
    if (bad != 0) $display("FAIL clr_dvalid: %0d cycles with dvalid=1, need 0", bad);
    else passed++;
    bad = 0;
    for (int a = 0; a < 32; a++) begin
      addr = a[4:0];
      step();
      if (dout !== 32'h0 || dvalid !== 1'b1) begin
        bad++;
        $display("FAIL clr_read addr %0d: dout=%h dvalid=%b, need 0 and 1", a, dout, dvalid);
      end
    end
    total++;
    if (bad == 0) passed++;
    cen = 0;
  endtask

  task automatic test_mid_sweep_reset();
    int n;
    do_write(5'd3, 32'h12345678, 4'hF);
    idle_inputs();
    reset = 1;
    step();
    reset = 0;
    for (int i = 0; i < 10; i++) step();
    reset = 1;
    step();
    total++;
    if (busy !== 1'b1) $display("FAIL mid_reset_busy: busy=%b, need 1", busy);
    else passed++;
    reset = 0;
    count_busy(n);
    total++;
    if (n !== 32) $display("FAIL mid_reset_len: got %0d cycles, need 32", n);
    else passed++;
    cen = 1; wen = 0; addr = 5'd3;
    step();
    total++;
    if (dout !== 32'h0 || dvalid !== 1'b1)
      $display("FAIL mid_reset_clear: dout=%h dvalid=%b, need 0 and 1", dout, dvalid);
    else passed++;
    cen = 0;
  endtask

  task automatic test_narrow();
    int n;
    reset2 = 1;
    step();
    reset2 = 0;
    n = 0;
    while (busy2 && n < 100) begin
      step();
      n++;
    end
    total++;
    if (n !== 8) $display("FAIL narrow_busy_len: got %0d cycles, need 8", n);
    else passed++;
    cen2 = 1; wen2 = 1; addr2 = 3'd7; din2 = 16'hA5A5; ben2 = 2'b10;
    step();
    wen2 = 0;
    step();
    total++;
    if (dout2 !== 16'hA500 || dvalid2 !== 1'b1)
      $display("FAIL narrow_byte: dout=%h dvalid=%b, need a500 and 1", dout2, dvalid2);
    else passed++;
    cen2 = 0;
  endtask

  initial begin
    reset = 1;
    idle_inputs();
    reset2 = 1; clr2 = 0; cen2 = 0; wen2 = 0; ben2 = '0; addr2 = '0; din2 = '0;
    test_reset();
    test_read_all_zero();
    test_write_read();
    test_byte_lanes();
    test_back_to_back();
    test_clear();
    test_mid_sweep_reset();
    test_narrow();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
